mem_access_stage: RTL



---
 rtl/mem_access_stage_pkg.sv | 45 ++++
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/mem_access_stage_load_extract.sv | 28 ++
 rtl/mem_access_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and field positions for the memory-access stage.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RD,
      DRAIN
   } mem_state_t;

   // mem_ctrl_i fields
   localparam int MC_RD     = 0;
   localparam int MC_WR     = 1;
   localparam int MC_SZ_LSB = 2;
   localparam int MC_UNS    = 4;

   // Control_Signal_i fields
   localparam int CS_SEL_LSB = 0;
   localparam int CS_WE      = 2;
   localparam int CS_RD_LSB  = 3;

   // 2'b11 has no defined meaning; it is handled as a word access
   function automatic mem_size_t decode_size(input logic [1:0] f);
      case (f)
         2'b00:   return BYTE;
         2'b01:   return HALF;
         default: return WORD;
      endcase
   endfunction

   function automatic logic [3:0] byte_enable(input mem_size_t s, input logic [1:0] off);
      case (s)
         BYTE:    return 4'b0001 << off;
         HALF:    return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/gnt/rvalid bus between the memory-access stage and data memory.
interface mem_access_stage_if #(
   parameter int size = 32
);
   logic            req;
   logic            we;
   logic [size-1:0] addr;
   logic [size-1:0] wdata;
   logic [3:0]      be;
   logic            gnt;
   logic            rvalid;
   logic [size-1:0] rdata;

   modport master (
      output req, we, addr, wdata, be,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_access_stage_load_extract.sv
// Load lane select plus sign/zero extension of the returned memory word.
module load_extract
   import mem_stage_pkg::*;
#(
   parameter int size = 32
) (
   input  logic [size-1:0] rdata_i,
   input  logic [1:0]      offset_i,
   input  mem_size_t       size_i,
   input  logic            unsigned_i,
   output logic [size-1:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
      half_sel = offset_i[1] ? rdata_i[16 +: 16] : rdata_i[0 +: 16];
      result_o = rdata_i;
      case (size_i)
         BYTE:    result_o = {{(size-8){~unsigned_i & byte_sel[7]}}, byte_sel};
         HALF:    result_o = {{(size-16){~unsigned_i & half_sel[15]}}, half_sel};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-memory loads/stores and registers results into write-back.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
//
// state   | meaning
// IDLE    | no transaction pending; accepts a new instruction
// REQ     | request presented, waiting for gnt
// WAIT_RD | load granted, waiting for rvalid
// DRAIN   | flushed load granted earlier, discarding its rvalid
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int size = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   input  logic             flush_i,
   input  logic [size-1:0]  FU_i,
   input  logic [size-1:0]  store_data_i,
   input  logic [size-1:0]  PCplus_i,
   input  logic [4:0]       mem_ctrl_i,
   input  logic [7:0]       Control_Signal_i,
   mem_access_stage_if.master dmem,
   output logic             stall_o,
   output logic             valid_o,
   output logic [size-1:0]  FU_o,
   output logic [size-1:0]  MEM_result_o,
   output logic [size-1:0]  PCplus_o,
   output logic [7:0]       Control_Signal_o
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic             misalign_o
`endif
);

   mem_state_t      state_q, state_d;
   logic [size-1:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]      be_q, be_d;
   logic            we_q, we_d, uns_q, uns_d;
   logic [1:0]      off_q, off_d;
   mem_size_t       msize_q, msize_d;
   logic [size-1:0] fu_lat_q, fu_lat_d, pc_lat_q, pc_lat_d;
   logic [7:0]      cs_lat_q, cs_lat_d;

   logic            valid_q, valid_d;
   logic [size-1:0] fu_o_q, fu_o_d, mem_q, mem_d, pc_o_q, pc_o_d;
   logic [7:0]      cs_o_q, cs_o_d;
`ifdef MEM_MISALIGN_TRAP_EN
   logic            misalign_q, misalign_d;
`endif

   logic            in_wr, in_mem, in_mis, accept;
   mem_size_t       in_size;
   logic [size-1:0] in_addr, in_wdata, ld_result;
   logic [3:0]      in_be;

   assign in_wr   = mem_ctrl_i[MC_WR];
   assign in_size = decode_size(mem_ctrl_i[MC_SZ_LSB +: 2]);
   assign in_addr = {FU_i[size-1:2], 2'b00};
   assign in_be   = byte_enable(in_size, FU_i[1:0]);
   assign accept  = valid_i & ~flush_i;

`ifdef MEM_MISALIGN_TRAP_EN
   assign in_mis = ((in_size == HALF) && FU_i[0]) || ((in_size == WORD) && (FU_i[1:0] != 2'b00));
`else
   assign in_mis = 1'b0;
`endif
   assign in_mem = (mem_ctrl_i[MC_RD] | in_wr) & ~in_mis;

   always_comb begin
      case (in_size)
         BYTE:    in_wdata = {(size/8){store_data_i[7:0]}};
         HALF:    in_wdata = {(size/16){store_data_i[15:0]}};
         default: in_wdata = store_data_i;
      endcase
   end

   load_extract #(.size(size)) u_load_extract (
      .rdata_i   (dmem.rdata),
      .offset_i  (off_q),
      .size_i    (msize_q),
      .unsigned_i(uns_q),
      .result_o  (ld_result)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      we_d     = we_q;
      off_d    = off_q;
      msize_d  = msize_q;
      uns_d    = uns_q;
      fu_lat_d = fu_lat_q;
      pc_lat_d = pc_lat_q;
      cs_lat_d = cs_lat_q;
      valid_d  = 1'b0;
      fu_o_d   = fu_o_q;
      mem_d    = mem_q;
      pc_o_d   = pc_o_q;
      cs_o_d   = '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_d = 1'b0;
`endif
      stall_o    = 1'b0;
      dmem.req   = 1'b0;
      dmem.we    = we_q;
      dmem.addr  = addr_q;
      dmem.wdata = wdata_q;
      dmem.be    = be_q;

      case (state_q)
         IDLE: begin
            dmem.we    = in_wr;
            dmem.addr  = in_addr;
            dmem.wdata = in_wdata;
            dmem.be    = in_be;
            if (accept) begin
               addr_d   = in_addr;
               wdata_d  = in_wdata;
               be_d     = in_be;
               we_d     = in_wr;
               off_d    = FU_i[1:0];
               msize_d  = in_size;
               uns_d    = mem_ctrl_i[MC_UNS];
               fu_lat_d = FU_i;
               pc_lat_d = PCplus_i;
               cs_lat_d = Control_Signal_i;
               dmem.req = in_mem;
               if (!in_mem || (dmem.gnt && in_wr)) begin
                  valid_d = 1'b1;
                  fu_o_d  = FU_i;
                  pc_o_d  = PCplus_i;
                  cs_o_d  = Control_Signal_i;
`ifdef MEM_MISALIGN_TRAP_EN
                  if (in_mis) begin
                     misalign_d     = 1'b1;
                     cs_o_d[CS_WE]  = 1'b0;
                  end
`endif
               end else begin
                  stall_o = 1'b1;
                  state_d = dmem.gnt ? WAIT_RD : REQ;
               end
            end
         end
         REQ: begin
            dmem.req = 1'b1;
            // a gnt seen together with flush still owes us an rvalid for loads
            if (flush_i) begin
               state_d = (dmem.gnt && !we_q) ? DRAIN : IDLE;
            end else if (dmem.gnt && we_q) begin
               valid_d = 1'b1;
               fu_o_d  = fu_lat_q;
               pc_o_d  = pc_lat_q;
               cs_o_d  = cs_lat_q;
               state_d = IDLE;
            end else begin
               stall_o = 1'b1;
               if (dmem.gnt) state_d = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (flush_i) begin
               state_d = dmem.rvalid ? IDLE : DRAIN;
            end else if (dmem.rvalid) begin
               valid_d = 1'b1;
               fu_o_d  = fu_lat_q;
               pc_o_d  = pc_lat_q;
               cs_o_d  = cs_lat_q;
               mem_d   = ld_result;
               state_d = IDLE;
            end else begin
               stall_o = 1'b1;
            end
         end
         default: begin
            stall_o = valid_i;
            if (dmem.rvalid) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         we_q     <= 1'b0;
         off_q    <= '0;
         msize_q  <= BYTE;
         uns_q    <= 1'b0;
         fu_lat_q <= '0;
         pc_lat_q <= '0;
         cs_lat_q <= '0;
         valid_q  <= 1'b0;
         fu_o_q   <= '0;
         mem_q    <= '0;
         pc_o_q   <= '0;
         cs_o_q   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         we_q     <= we_d;
         off_q    <= off_d;
         msize_q  <= msize_d;
         uns_q    <= uns_d;
         fu_lat_q <= fu_lat_d;
         pc_lat_q <= pc_lat_d;
         cs_lat_q <= cs_lat_d;
         valid_q  <= valid_d;
         fu_o_q   <= fu_o_d;
         mem_q    <= mem_d;
         pc_o_q   <= pc_o_d;
         cs_o_q   <= cs_o_d;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   assign valid_o          = valid_q;
   assign FU_o             = fu_o_q;
   assign MEM_result_o     = mem_q;
   assign PCplus_o         = pc_o_q;
   assign Control_Signal_o = cs_o_q;
`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_o       = misalign_q;
`endif

endmodule
